vx_dp_ram_ctrl: RTL and testbench
=================================

// Module: VX_dp_ram_ctrl
// PURPOSE
//  Request-side controller that drives an external dual-port RAM.
//  - Accepts read/write requests on a valid/ready port and drives the RAM write port (wren/waddr/wdata) and read port (raddr/rdata).
//  - Returns read data on a valid/ready response port, using credit-based flow control. Responses are never dropped under backpressure.
//  - Sits between core-side clients (e.g. cache tag/data arrays) and the RAM macro.
// PARAMETERS
//  DATAW      32             data width in bits
//  SIZE       256            RAM depth in words
//  BYTEENW    1              write-enable width: 1 (word) or DATAW/8 (byte); any other value is a static assert
//  OUT_REG    0              must match the RAM: 0 = combinational rdata, 1 = registered rdata
//  RSP_DEPTH  4              response FIFO entries = max reads outstanding; >= 1; full rate needs >= OUT_REG+2
//  ADDRW      $clog2(SIZE)   address width
// PORTS
//  clk         in   1        clock
//  reset       in   1        synchronous, active-high reset
//  req_valid   in   1        request valid
//  req_rw      in   1        1 = write, 0 = read
//  req_addr    in   ADDRW    word address
//  req_data    in   DATAW    write data
//  req_byteen  in   BYTEENW  write byte enables (ignored for reads)
//  req_ready   out  1        request accepted when req_valid && req_ready
//  rsp_valid   out  1        read response valid
//  rsp_data    out  DATAW    read response data
//  rsp_ready   in   1        response consumer ready
//  ram_wren    out  BYTEENW  RAM write enable
//  ram_waddr   out  ADDRW    RAM write address
//  ram_wdata   out  DATAW    RAM write data
//  ram_raddr   out  ADDRW    RAM read address
//  ram_rdata   in   DATAW    RAM read data
// BEHAVIOUR
//  - Writes: req_ready=1 unconditionally.
//    ram_wren = (req_valid && req_rw) ? req_byteen : 0, in the same cycle (combinational).
//    ram_waddr = req_addr, ram_wdata = req_data. Writes produce no response.
//  - Reads: req_ready = (credits != 0).
//    credits is a registered count, reset to RSP_DEPTH. It decrements on read accept and increments on rsp handshake.
//    If both happen in one cycle it is unchanged.
//    There is no combinational path rsp_ready -> req_ready.
//  - ram_raddr = req_addr (combinational), regardless of request type.
//  - Read pipeline: a 1-bit valid shift register of length OUT_REG aligns capture with ram_rdata.
//    OUT_REG=0: ram_rdata is pushed into the FIFO at the end of the accept cycle t; rsp_valid is earliest at t+1.
//    OUT_REG=1: capture at the end of t+1; rsp_valid is earliest at t+2.
//  - Response FIFO: RSP_DEPTH registers with wrapping rd/wr pointers.
//    rsp_valid = !empty; rsp_data = head entry, stable while rsp_valid && !rsp_ready.
//    Push and pop in the same cycle is legal, including when full or empty-with-push.
//  - Credits guarantee that a push never hits a full FIFO; overflow is an assertion failure.
//  - Ordering: responses come out in read-accept order. A read accepted the cycle after a write to the same address returns the new data.
//  - Reset (synchronous; also mid-operation):
//    rsp_valid=0, FIFO empty, pointers=0, credits=RSP_DEPTH, shift register cleared.
//    In-flight reads are discarded; completed RAM writes persist.
//    ram_wren=0 while reset is high, regardless of req_valid; req_ready=0 during reset.
//  - Minimum read-to-read interval is 1 cycle while credits last.
// TESTING
//  - OUT_REG=0: write 0xDEADBEEF @0x10, then read 0x10 next cycle -> rsp_valid one cycle after the read accept, rsp_data=0xDEADBEEF.
//  - BYTEENW=4: write 0x11223344 @5, then write 0xAABBCCDD with byteen=4'b0101 @5, then read @5 -> 0x11BB33DD.
//  - RSP_DEPTH=4, rsp_ready=0: issue 6 reads -> exactly 4 accepted, then req_ready=0.
//    Raise rsp_ready -> the 4 responses arrive in order, then the remaining 2 are accepted.
//  - OUT_REG=1, RSP_DEPTH=3, rsp_ready=1: 16 back-to-back reads -> 16 accepts in 16 cycles, first rsp at +2, no bubbles.
//  - Assert reset with 3 responses queued and 1 read in flight -> next cycle rsp_valid=0, req_ready=0.
//    After release: credits=RSP_DEPTH, and earlier writes are still readable.
//  - Random mix of reads/writes with random rsp_ready against a reference memory model -> all data matches, order is preserved, no overflow.

Source files
------------

// File: rtl/vx_dp_ram_ctrl.sv
// Request-side controller for an external dual-port RAM: forwards writes directly,
// issues reads and returns their data through a credit-guarded response FIFO.
module vx_dp_ram_ctrl #(
  parameter int DATAW     = 32,
  parameter int SIZE      = 256,
  parameter int BYTEENW   = 1,
  parameter int OUT_REG   = 0,
  parameter int RSP_DEPTH = 4,
  parameter int ADDRW     = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_rw,
  input  logic [ADDRW-1:0]   req_addr,
  input  logic [DATAW-1:0]   req_data,
  input  logic [BYTEENW-1:0] req_byteen,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic [DATAW-1:0]   rsp_data,
  input  logic               rsp_ready,
  output logic [BYTEENW-1:0] ram_wren,
  output logic [ADDRW-1:0]   ram_waddr,
  output logic [DATAW-1:0]   ram_wdata,
  output logic [ADDRW-1:0]   ram_raddr,
  input  logic [DATAW-1:0]   ram_rdata
);

  localparam int PTRW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNTW = $clog2(RSP_DEPTH + 1);

  generate
    if ((BYTEENW != 1 && BYTEENW != DATAW / 8) || RSP_DEPTH < 1) begin : g_bad_params
      $error("vx_dp_ram_ctrl: BYTEENW must be 1 or DATAW/8 and RSP_DEPTH >= 1");
    end
  endgenerate

  logic [CNTW-1:0]  credits_q, credits_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATAW-1:0] fifo_q [RSP_DEPTH];
  logic             rd_fire, push, pop, full;

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p == PTRW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Read acceptance depends only on registered credits, never on rsp_ready.
  assign req_ready = !reset && (req_rw || (credits_q != '0));
  assign rd_fire   = req_valid && req_ready && !req_rw;
  assign ram_wren  = (req_valid && req_rw && !reset) ? req_byteen : '0;
  assign ram_waddr = req_addr;
  assign ram_wdata = req_data;
  assign ram_raddr = req_addr;

  generate
    if (OUT_REG == 0) begin : g_comb_rdata
      assign push = rd_fire;
    end else begin : g_reg_rdata
      logic [OUT_REG-1:0] pipe_q, pipe_d;
      assign pipe_d = (pipe_q << 1) | OUT_REG'(rd_fire);
      assign push   = pipe_q[OUT_REG-1];
      always_ff @(posedge clk) begin
        if (reset) pipe_q <= '0;
        else       pipe_q <= pipe_d;
      end
    end
  endgenerate

  assign rsp_valid = (count_q != '0);
  assign full      = (count_q == CNTW'(RSP_DEPTH));
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = fifo_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    credits_d = credits_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    case ({rd_fire, pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q <= CNTW'(RSP_DEPTH);
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      credits_q <= credits_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // NOTE: FIFO storage has no reset; empty pointers already mask stale contents.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= ram_rdata;
  end

  // Credits must make a push into a full FIFO (without a pop) impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: tb/tb_vx_dp_ram_ctrl.sv
// Bench for vx_dp_ram_ctrl: two instances (comb/registered RAM read, depth 4/3) driven by
// directed vectors, corner sequences and random traffic against a memory/queue model.
module tb_vx_dp_ram_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int BW = 4;

  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [DW-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid  [2];
  logic          req_rw     [2];
  logic [AW-1:0] req_addr   [2];
  logic [DW-1:0] req_data   [2];
  logic [BW-1:0] req_byteen [2];
  logic          req_ready  [2];
  logic          rsp_valid  [2];
  logic [DW-1:0] rsp_data   [2];
  logic          rsp_ready  [2];
  logic [BW-1:0] ram_wren   [2];
  logic [AW-1:0] ram_waddr  [2];
  logic [DW-1:0] ram_wdata  [2];
  logic [AW-1:0] ram_raddr  [2];
  logic [DW-1:0] ram_rdata  [2];

  always #5 clk = ~clk;

  vx_dp_ram_ctrl #(.DATAW(DW), .SIZE(256), .BYTEENW(BW), .OUT_REG(0), .RSP_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_rw(req_rw[0]), .req_addr(req_addr[0]),
    .req_data(req_data[0]), .req_byteen(req_byteen[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_ready(rsp_ready[0]),
    .ram_wren(ram_wren[0]), .ram_waddr(ram_waddr[0]), .ram_wdata(ram_wdata[0]),
    .ram_raddr(ram_raddr[0]), .ram_rdata(ram_rdata[0])
  );

  vx_dp_ram_ctrl #(.DATAW(DW), .SIZE(256), .BYTEENW(BW), .OUT_REG(1), .RSP_DEPTH(3)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_rw(req_rw[1]), .req_addr(req_addr[1]),
    .req_data(req_data[1]), .req_byteen(req_byteen[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_ready(rsp_ready[1]),
    .ram_wren(ram_wren[1]), .ram_waddr(ram_waddr[1]), .ram_wdata(ram_wdata[1]),
    .ram_raddr(ram_raddr[1]), .ram_rdata(ram_rdata[1])
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [BW-1:0] be);
    merge = o;
    for (int b = 0; b < BW; b++)
      if (be[b]) merge[8*b +: 8] = n[8*b +: 8];
  endfunction

  // External RAM macros: instance 0 reads combinationally, instance 1 through a register.
  logic [DW-1:0] ram [2][256];
  logic [DW-1:0] rdata_q1;

  always @(posedge clk) begin
    if (ram_wren[0] != '0) ram[0][ram_waddr[0]] <= merge(ram[0][ram_waddr[0]], ram_wdata[0], ram_wren[0]);
    if (ram_wren[1] != '0) ram[1][ram_waddr[1]] <= merge(ram[1][ram_waddr[1]], ram_wdata[1], ram_wren[1]);
    rdata_q1 <= ram[1][ram_raddr[1]];
  end

  assign ram_rdata[0] = ram[0][ram_raddr[0]];
  assign ram_rdata[1] = rdata_q1;

  // Reference model: word memory per instance plus the queue of reads owed to the consumer.
  logic [DW-1:0] mdl [2][256];
  logic [DW-1:0] expq [$];

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  bit            got_rsp, got_acc;
  logic [DW-1:0] got_data;
  vec_t          tbl [10];

  function automatic int depth(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    req_valid[i]  = v;
    req_rw[i]     = rw;
    req_addr[i]   = a;
    req_data[i]   = d;
    req_byteen[i] = be;
  endtask

  // One clock cycle on instance i: compare outputs mid-cycle, then advance the model.
  task automatic step(input int i);
    logic exp_rdy;
    int   outs;
    @(negedge clk);
    got_rsp = 1'b0;
    got_acc = 1'b0;
    if (reset) begin
      check("rst_req_ready", req_ready[i], 1'b0);
      check("rst_ram_wren", ram_wren[i], '0);
      expq.delete();
    end else begin
      outs    = expq.size();
      exp_rdy = req_rw[i] || (outs < depth(i));
      check("req_ready", req_ready[i], exp_rdy);
      check("ram_wren", ram_wren[i], (req_valid[i] && req_rw[i]) ? req_byteen[i] : 4'h0);
      check("ram_raddr", ram_raddr[i], req_addr[i]);
      if (req_valid[i] && req_rw[i]) check("ram_waddr", ram_waddr[i], req_addr[i]);
      if (rsp_valid[i] && rsp_ready[i]) begin
        got_rsp  = 1'b1;
        got_data = rsp_data[i];
        if (outs == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_spurious: rsp_valid=1 expected 0 with no read outstanding (cycle %0d)", cyc);
        end else begin
          check("rsp_data", rsp_data[i], expq.pop_front());
        end
      end
      if (req_valid[i] && exp_rdy) begin
        got_acc = 1'b1;
        if (req_rw[i]) mdl[i][req_addr[i]] = merge(mdl[i][req_addr[i]], req_data[i], req_byteen[i]);
        else           expq.push_back(mdl[i][req_addr[i]]);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic setup_mem(input int i);
    for (int a = 0; a < 32; a++) begin
      drive(i, 1'b1, 1'b1, AW'(a), $urandom, 4'hF);
      step(i);
    end
    drive(i, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic drain(input int i, input string name);
    drive(i, 1'b0, 1'b0, '0, '0, '0);
    rsp_ready[i] = 1'b1;
    for (int c = 0; c < 20 && expq.size() != 0; c++) step(i);
    check({name, "_drained"}, expq.size(), 0);
    step(i);
    check({name, "_rsp_idle"}, rsp_valid[i], 1'b0);
  endtask

  task automatic backpressure_seq();
    int acc, nrsp;
    for (int a = 0; a < 6; a++) begin
      drive(0, 1'b1, 1'b1, AW'(8'h40 + a), 32'h0BAD_0000 + a, 4'hF);
      step(0);
    end
    rsp_ready[0] = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      drive(0, 1'b1, 1'b0, AW'(8'h40 + acc), '0, '0);
      step(0);
      if (got_acc) acc++;
    end
    check("bp_accepts_stalled", acc, 4);
    check("bp_ready_low", req_ready[0], 1'b0);
    rsp_ready[0] = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 40 && (acc < 6 || expq.size() != 0); c++) begin
      drive(0, acc < 6, 1'b0, AW'(8'h40 + acc), '0, '0);
      step(0);
      if (got_acc) acc++;
      if (got_rsp) nrsp++;
    end
    check("bp_accepts_total", acc, 6);
    check("bp_rsp_total", nrsp, 6);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic reset_seq();
    int acc, nrsp;
    for (int a = 0; a < 4; a++) begin
      drive(0, 1'b1, 1'b1, AW'(8'h50 + a), 32'h5EED_0000 + a, 4'hF);
      step(0);
    end
    rsp_ready[0] = 1'b0;
    for (int a = 0; a < 3; a++) begin
      drive(0, 1'b1, 1'b0, AW'(8'h50 + a), '0, '0);
      step(0);
    end
    drive(0, 1'b1, 1'b0, 8'h53, '0, '0);
    reset = 1'b1;
    step(0);
    check("rst_mid_rsp_valid", rsp_valid[0], 1'b0);
    check("rst_mid_req_ready", req_ready[0], 1'b0);
    step(0);
    reset = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 1'b1, 1'b0, AW'(8'h50 + (acc % 4)), '0, '0);
      step(0);
      if (got_acc) acc++;
    end
    check("rst_credits_restored", acc, 4);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    rsp_ready[0] = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 20 && expq.size() != 0; c++) begin
      step(0);
      if (got_rsp) nrsp++;
    end
    check("rst_rsp_after", nrsp, 4);
  endtask

  task automatic full_rate_seq();
    int acc, nrsp, first_acc, first_rsp, last_rsp, c0;
    for (int a = 0; a < 16; a++) begin
      drive(1, 1'b1, 1'b1, AW'(8'h60 + a), $urandom, 4'hF);
      step(1);
    end
    rsp_ready[1] = 1'b1;
    acc = 0; nrsp = 0; first_acc = -1; first_rsp = -1; last_rsp = -1;
    for (int c = 0; c < 26; c++) begin
      drive(1, c < 16, 1'b0, AW'(8'h60 + c), '0, '0);
      c0 = cyc;
      step(1);
      if (got_acc) begin
        if (first_acc < 0) first_acc = c0;
        acc++;
      end
      if (got_rsp) begin
        if (first_rsp < 0) first_rsp = c0;
        last_rsp = c0;
        nrsp++;
      end
      if (c == 15) check("fr_accepts_16_cycles", acc, 16);
    end
    check("fr_first_rsp_latency", first_rsp - first_acc, 2);
    check("fr_rsp_count", nrsp, 16);
    check("fr_no_bubbles", last_rsp - first_rsp, 15);
  endtask

  task automatic random_seq(input int i);
    for (int n = 0; n < 400; n++) begin
      drive(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)),
            $urandom, BW'($urandom_range(0, 15)));
      rsp_ready[i] = $urandom_range(0, 2) != 0;
      step(i);
    end
    drain(i, "rand");
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 8'h05, 32'h11223344, 4'hF, 32'h0};
    tbl[3] = '{1'b1, 8'h05, 32'hAABBCCDD, 4'h5, 32'h0};
    tbl[4] = '{1'b0, 8'h05, 32'h0,        4'h0, 32'h11BB33DD};
    tbl[5] = '{1'b1, 8'hFF, 32'h12345678, 4'hF, 32'h0};
    tbl[6] = '{1'b0, 8'hFF, 32'h0,        4'h0, 32'h12345678};
    tbl[7] = '{1'b1, 8'h00, 32'hCAFEF00D, 4'hF, 32'h0};
    tbl[8] = '{1'b1, 8'h00, 32'hA5A5A5A5, 4'h8, 32'h0};
    tbl[9] = '{1'b0, 8'h00, 32'h0,        4'h0, 32'hA5FEF00D};

    for (int i = 0; i < 2; i++) begin
      drive(i, 1'b0, 1'b0, '0, '0, '0);
      rsp_ready[i] = 1'b0;
    end
    reset = 1'b1;
    drive(0, 1'b1, 1'b1, 8'h01, 32'hFFFF_FFFF, 4'hF);
    step(0);
    step(0);
    check("rst_rsp_valid0", rsp_valid[0], 1'b0);
    check("rst_rsp_valid1", rsp_valid[1], 1'b0);
    check("rst_req_ready1", req_ready[1], 1'b0);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0, '0);

    for (int i = 0; i < 2; i++) begin
      setup_mem(i);
      for (int k = 0; k < 10; k++) begin : tbl_loop
        int n;
        drive(i, 1'b1, tbl[k].rw, tbl[k].addr, tbl[k].data, tbl[k].be);
        rsp_ready[i] = 1'b1;
        step(i);
        if (!tbl[k].rw) begin
          req_valid[i] = 1'b0;
          n = 0;
          do begin
            step(i);
            n++;
          end while (!got_rsp && n < 8);
          check("tbl_latency", n, i + 1);
          check("tbl_data", got_data, tbl[k].exp);
        end
      end
      drive(i, 1'b0, 1'b0, '0, '0, '0);
      if (i == 0) begin
        backpressure_seq();
        reset_seq();
      end else begin
        full_rate_seq();
      end
      random_seq(i);
      rsp_ready[i] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
